// File: rtl/game_state_sequencer.sv
// rtl/game_state_sequencer.sv - game tick generator and life/invincibility sequencer
//
// Ports:
//   CLK         system clock, rising edge
//   RESET       asynchronous active-high reset
//   START       start button level (synchronous to CLK)
//   COLLIDE     square/block overlap level
//   TICK        one-cycle game tick strobe, every TICK_DIV cycles
//   GAME_READY  high while waiting for a start event
//   HURT        one-cycle pulse per accepted hit
//   INVINCIBLE  high during the post-hit invincibility window
//   RECOVER     one-cycle pulse when invincibility ends
//   OVER        high while the game is over
//   LIVES_LEFT  remaining lives

module game_state_sequencer #(
  parameter int TICK_DIV  = 1000000,
  parameter int LIVES     = 3,
  parameter int INV_TICKS = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       COLLIDE,
  output logic       TICK,
  output logic       GAME_READY,
  output logic       HURT,
  output logic       INVINCIBLE,
  output logic       RECOVER,
  output logic       OVER,
  output logic [2:0] LIVES_LEFT
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_INV  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [7:0]    inv_timer;
  logic          start_q;
  logic          start_evt;

  // Free-running tick divider; runs regardless of game state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CW'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // Count is zero while in reset, so TICK is low there as well.
  assign TICK = (tick_cnt == CW'(TICK_DIV - 1));

  // History resets to 1 so a button held through reset release is not an event.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      start_q <= 1'b1;
    end else begin
      start_q <= START;
    end
  end

  assign start_evt = START & ~start_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      inv_timer  <= 8'd0;
      LIVES_LEFT <= 3'(LIVES);
      GAME_READY <= 1'b1;
      HURT       <= 1'b0;
      INVINCIBLE <= 1'b0;
      RECOVER    <= 1'b0;
      OVER       <= 1'b0;
    end else begin
      HURT    <= 1'b0;
      RECOVER <= 1'b0;
      case (state)
        S_IDLE: begin
          GAME_READY <= 1'b1;
          if (start_evt) begin
            state      <= S_RUN;
            LIVES_LEFT <= 3'(LIVES);
            GAME_READY <= 1'b0;
          end
        end
        S_RUN: begin
          if (COLLIDE) begin
            HURT <= 1'b1;
            // Last life (or defensively none left): clamp at zero.
            if (LIVES_LEFT <= 3'd1) begin
              LIVES_LEFT <= 3'd0;
              state      <= S_OVER;
              OVER       <= 1'b1;
            end else begin
              LIVES_LEFT <= LIVES_LEFT - 3'd1;
              inv_timer  <= 8'(INV_TICKS);
              state      <= S_INV;
              INVINCIBLE <= 1'b1;
            end
          end
        end
        S_INV: begin
          // COLLIDE is deliberately not looked at here, including on the
          // expiring tick; the first RUN cycle is the first that can hit.
          if (TICK) begin
            if (inv_timer <= 8'd1) begin
              inv_timer  <= 8'd0;
              state      <= S_RUN;
              INVINCIBLE <= 1'b0;
              RECOVER    <= 1'b1;
            end else begin
              inv_timer <= inv_timer - 8'd1;
            end
          end
        end
        S_OVER: begin
          OVER <= 1'b1;
          if (start_evt) begin
            state      <= S_IDLE;
            OVER       <= 1'b0;
            GAME_READY <= 1'b1;
            LIVES_LEFT <= 3'(LIVES);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_sequencer.sv
// tb/tb_game_state_sequencer.sv - directed self-checking bench for game_state_sequencer

module tb_game_state_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       collide;
  logic       tick;
  logic       game_ready;
  logic       hurt;
  logic       invincible;
  logic       recover;
  logic       over;
  logic [2:0] lives_left;

  int checks;
  int failures;
  int cyc;

  game_state_sequencer #(
    .TICK_DIV (4),
    .LIVES    (2),
    .INV_TICKS(3)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .START     (start),
    .COLLIDE   (collide),
    .TICK      (tick),
    .GAME_READY(game_ready),
    .HURT      (hurt),
    .INVINCIBLE(invincible),
    .RECOVER   (recover),
    .OVER      (over),
    .LIVES_LEFT(lives_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Holds reset for two edges, releases at a negedge; that negedge is cycle 0.
  task automatic do_reset(input logic start_level);
    rst     = 1'b1;
    start   = start_level;
    collide = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Reset, then a clean 0->1 start; ends at cycle 2 in RUN with START low.
  task automatic do_reset_start();
    do_reset(1'b0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; collide = 1'b0;
    #1;
    checks++;
    if ({tick, game_ready, hurt, invincible, recover, over, lives_left} !== {6'b010000, 3'd2}) begin
      failures++;
      $display("FAIL reset_values got=%b required=%b", {tick, game_ready, hurt, invincible, recover, over, lives_left}, {6'b010000, 3'd2});
    end
    do_reset(1'b0);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (tick !== ((cyc % 4) == 3)) begin
        failures++;
        $display("FAIL idle_tick cyc=%0d got=%b required=%b", cyc, tick, ((cyc % 4) == 3));
      end
      checks++;
      if (game_ready !== 1'b1 || lives_left !== 3'd2 || over !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d got ready=%b lives=%0d over=%b required ready=1 lives=2 over=0", cyc, game_ready, lives_left, over);
      end
      step();
    end
  endtask

  task automatic test_start_held();
    do_reset(1'b1);
    repeat (3) step();
    checks++;
    if (game_ready !== 1'b1) begin
      failures++;
      $display("FAIL held_start_ignored got ready=%b required=1", game_ready);
    end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    checks++;
    if (game_ready !== 1'b0 || lives_left !== 3'd2) begin
      failures++;
      $display("FAIL start_edge got ready=%b lives=%0d required ready=0 lives=2", game_ready, lives_left);
    end
    start = 1'b0;
  endtask

  task automatic test_hit_recover();
    do_reset_start();
    collide = 1'b1;
    step();
    collide = 1'b0;
    checks++;
    if (hurt !== 1'b1 || lives_left !== 3'd1 || invincible !== 1'b1 || tick !== 1'b1) begin
      failures++;
      $display("FAIL hit got hurt=%b lives=%0d inv=%b tick=%b required 1 1 1 1", hurt, lives_left, invincible, tick);
    end
    repeat (8) begin
      step();
      checks++;
      if (invincible !== 1'b1 || hurt !== 1'b0 || recover !== 1'b0 || tick !== ((cyc % 4) == 3)) begin
        failures++;
        $display("FAIL inv_window cyc=%0d got inv=%b hurt=%b rec=%b tick=%b required inv=1 hurt=0 rec=0 tick=%b", cyc, invincible, hurt, recover, tick, ((cyc % 4) == 3));
      end
    end
    step();
    checks++;
    if (recover !== 1'b1 || invincible !== 1'b0 || hurt !== 1'b0 || lives_left !== 3'd1) begin
      failures++;
      $display("FAIL recover cyc=%0d got rec=%b inv=%b hurt=%b lives=%0d required 1 0 0 1", cyc, recover, invincible, hurt, lives_left);
    end
    step();
    checks++;
    if (recover !== 1'b0 || hurt !== 1'b0 || invincible !== 1'b0) begin
      failures++;
      $display("FAIL recover_pulse_width got rec=%b hurt=%b inv=%b required 0 0 0", recover, hurt, invincible);
    end
  endtask

  task automatic test_collide_held();
    do_reset_start();
    collide = 1'b1;
    step();
    checks++;
    if (hurt !== 1'b1 || lives_left !== 3'd1) begin
      failures++;
      $display("FAIL held_first_hit got hurt=%b lives=%0d required 1 1", hurt, lives_left);
    end
    repeat (8) begin
      step();
      checks++;
      if (hurt !== 1'b0 || invincible !== 1'b1) begin
        failures++;
        $display("FAIL held_inv_ignores cyc=%0d got hurt=%b inv=%b required 0 1", cyc, hurt, invincible);
      end
    end
    step();
    checks++;
    if (recover !== 1'b1 || hurt !== 1'b0) begin
      failures++;
      $display("FAIL held_recover got rec=%b hurt=%b required 1 0", recover, hurt);
    end
    step();
    checks++;
    if (hurt !== 1'b1 || over !== 1'b1 || lives_left !== 3'd0 || recover !== 1'b0 || invincible !== 1'b0) begin
      failures++;
      $display("FAIL final_hit got hurt=%b over=%b lives=%0d rec=%b inv=%b required 1 1 0 0 0", hurt, over, lives_left, recover, invincible);
    end
    repeat (6) begin
      step();
      checks++;
      if (hurt !== 1'b0 || over !== 1'b1 || lives_left !== 3'd0) begin
        failures++;
        $display("FAIL over_hold cyc=%0d got hurt=%b over=%b lives=%0d required 0 1 0", cyc, hurt, over, lives_left);
      end
    end
  endtask

  // Continues from the OVER state left by test_collide_held.
  task automatic test_over_restart();
    start = 1'b1;
    step();
    checks++;
    if (over !== 1'b0 || game_ready !== 1'b1 || lives_left !== 3'd2 || hurt !== 1'b0) begin
      failures++;
      $display("FAIL over_restart got over=%b ready=%b lives=%0d hurt=%b required 0 1 2 0", over, game_ready, lives_left, hurt);
    end
    start = 1'b0;
    step();
    checks++;
    if (game_ready !== 1'b1 || hurt !== 1'b0 || lives_left !== 3'd2) begin
      failures++;
      $display("FAIL idle_after_over got ready=%b hurt=%b lives=%0d required 1 0 2", game_ready, hurt, lives_left);
    end
    collide = 1'b0;
  endtask

  task automatic test_start_ignored();
    do_reset_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (game_ready !== 1'b0 || over !== 1'b0 || invincible !== 1'b0 || lives_left !== 3'd2) begin
      failures++;
      $display("FAIL start_in_run got ready=%b over=%b inv=%b lives=%0d required 0 0 0 2", game_ready, over, invincible, lives_left);
    end
    collide = 1'b1;
    step();
    collide = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (invincible !== 1'b1 || game_ready !== 1'b0 || lives_left !== 3'd1) begin
      failures++;
      $display("FAIL start_in_inv got inv=%b ready=%b lives=%0d required 1 0 1", invincible, game_ready, lives_left);
    end
  endtask

  task automatic test_reset_mid_inv();
    do_reset_start();
    collide = 1'b1;
    step();
    collide = 1'b0;
    step();
    step();
    checks++;
    if (invincible !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_inv got inv=%b required 1", invincible);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tick, game_ready, hurt, invincible, recover, over, lives_left} !== {6'b010000, 3'd2}) begin
      failures++;
      $display("FAIL async_reset got=%b required=%b", {tick, game_ready, hurt, invincible, recover, over, lives_left}, {6'b010000, 3'd2});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (recover !== 1'b0 || hurt !== 1'b0 || invincible !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold got rec=%b hurt=%b inv=%b required 0 0 0", recover, hurt, invincible);
      end
    end
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tick !== ((cyc % 4) == 3) || game_ready !== 1'b1 || recover !== 1'b0) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got tick=%b ready=%b rec=%b required tick=%b ready=1 rec=0", cyc, tick, game_ready, recover, ((cyc % 4) == 3));
      end
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    collide  = 1'b0;
    test_reset();
    test_start_held();
    test_hit_recover();
    test_collide_held();
    test_over_restart();
    test_start_ignored();
    test_reset_mid_inv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
